// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD1602 bus arbiter.
// Optional power-up init sequence is enabled by defining LCD_ARB_INIT_EN.
package lcd_pkg;

    // Arbiter / sequencer states
    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        IDLE,
        SETUP,
        STROBE,
        CLRWAIT
    } lcd_state_e;

    // Strobe timer phases
    typedef enum logic [1:0] {
        PH_OFF,
        PH_LOW,
        PH_HIGH,
        PH_WAIT
    } lcd_phase_e;

    // Default timing, in clk cycles
    localparam int LCD_T_HALF_DEF  = 50000;
    localparam int LCD_T_PWRUP_DEF = 750000;
    localparam int LCD_T_CLR_DEF   = 100000;

    // Power-up init commands, issued in this order
    localparam logic [7:0] INIT_CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] INIT_CMD_OFF   = 8'h08;  // display off
    localparam logic [7:0] INIT_CMD_CLR   = 8'h01;  // clear display
    localparam logic [7:0] INIT_CMD_ENTRY = 8'h06;  // increment, no shift
    localparam logic [7:0] INIT_CMD_ON    = 8'h0C;  // display on, cursor off
    localparam int         INIT_LEN       = 5;

    // LCD command codes
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side handshake bundle for the LCD bus arbiter (two requesters).
interface lcd_bus_arbiter_if;
    logic [1:0]      req_valid;
    logic [1:0]      req_rs;
    logic [1:0][7:0] req_data;
    logic [1:0]      req_lock;
    logic [1:0]      req_ready;

    modport master (output req_valid, output req_rs, output req_data,
                    output req_lock, input req_ready);
    modport slave  (input req_valid, input req_rs, input req_data,
                    input req_lock, output req_ready);
endinterface

// File: rtl/lcd_strobe_timer.sv
// Phase counter and lcd_en generator: T_HALF cycles low, T_HALF cycles high,
// then optionally a T_CLR-cycle wait for slow clear/home commands.
module lcd_strobe_timer
    import lcd_pkg::*;
#(
    parameter int T_HALF = LCD_T_HALF_DEF,
    parameter int T_CLR  = LCD_T_CLR_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic clr_wait_i,
    output logic low_done_o,
    output logic high_done_o,
    output logic wait_done_o,
    output logic lcd_en_o
);
    localparam int CW = $clog2(((T_HALF > T_CLR) ? T_HALF : T_CLR) + 1);

    lcd_phase_e    phase_q;
    logic [CW-1:0] cnt_q;
    logic          en_q;

    // Each phase counts down to zero; the done flags mark its last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_OFF;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            case (phase_q)
                PH_OFF: begin
                    if (start_i) begin
                        phase_q <= PH_LOW;
                        cnt_q   <= CW'(T_HALF - 1);
                    end
                end
                PH_LOW: begin
                    if (cnt_q == '0) begin
                        phase_q <= PH_HIGH;
                        cnt_q   <= CW'(T_HALF - 1);
                        en_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (cnt_q == '0) begin
                        en_q <= 1'b0;
                        if (clr_wait_i) begin
                            phase_q <= PH_WAIT;
                            cnt_q   <= CW'(T_CLR - 1);
                        end else begin
                            phase_q <= PH_OFF;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PH_WAIT: begin
                    if (cnt_q == '0) begin
                        phase_q <= PH_OFF;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: phase_q <= PH_OFF;
            endcase
        end
    end

    assign low_done_o  = (phase_q == PH_LOW)  && (cnt_q == '0);
    assign high_done_o = (phase_q == PH_HIGH) && (cnt_q == '0);
    assign wait_done_o = (phase_q == PH_WAIT) && (cnt_q == '0);
    assign lcd_en_o    = en_q;
endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter driving a shared LCD1602 8-bit bus.
// Round-robin grant with optional lock; define LCD_ARB_INIT_EN to run the
// power-up init command sequence, otherwise the bus is ready after PWRUP.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int T_HALF  = LCD_T_HALF_DEF,
    parameter int T_PWRUP = LCD_T_PWRUP_DEF,
    parameter int T_CLR   = LCD_T_CLR_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    lcd_bus_arbiter_if.slave   bus,
    output logic               lcd_rs,
    output logic               lcd_en,
    output logic               lcd_rw,
    output logic [7:0]         lcd_data,
    output logic               init_done,
    output logic               busy
);
    localparam int PW = (T_PWRUP > 1) ? $clog2(T_PWRUP) : 1;

    lcd_state_e    state_q;
    logic [PW-1:0] pwr_cnt_q;
    logic          init_done_q, busy_q, rs_q, last_q, lock_vld_q, lock_id_q;
    logic [7:0]    data_q;
    logic          grant_vld, grant_id;
    logic          clr_wait, init_issue, xfer_end;
    logic          low_done, high_done, wait_done;

`ifdef LCD_ARB_INIT_EN
    logic [2:0] init_idx_q;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return INIT_CMD_FUNC;
            3'd1:    return INIT_CMD_OFF;
            3'd2:    return INIT_CMD_CLR;
            3'd3:    return INIT_CMD_ENTRY;
            default: return INIT_CMD_ON;
        endcase
    endfunction

    assign init_issue = (state_q == INIT);
`else
    assign init_issue = 1'b0;
`endif

    // Grant selection: locked owner first, then round-robin, then lone requester
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE && init_done_q) begin
            if (lock_vld_q) begin
                grant_id  = lock_id_q;
                grant_vld = bus.req_valid[lock_id_q];
            end else if (&bus.req_valid) begin
                grant_id  = ~last_q;
                grant_vld = 1'b1;
            end else if (bus.req_valid[0]) begin
                grant_id  = 1'b0;
                grant_vld = 1'b1;
            end else if (bus.req_valid[1]) begin
                grant_id  = 1'b1;
                grant_vld = 1'b1;
            end
        end
    end

    assign bus.req_ready = {grant_vld & grant_id, grant_vld & ~grant_id};
    assign clr_wait = !rs_q && (data_q == LCD_CMD_CLEAR || data_q == LCD_CMD_HOME);
    assign xfer_end = (state_q == STROBE  && high_done && !clr_wait) ||
                      (state_q == CLRWAIT && wait_done);

    lcd_strobe_timer #(.T_HALF(T_HALF), .T_CLR(T_CLR)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (grant_vld | init_issue),
        .clr_wait_i  (clr_wait),
        .low_done_o  (low_done),
        .high_done_o (high_done),
        .wait_done_o (wait_done),
        .lcd_en_o    (lcd_en)
    );

    // Sequencer: power-up wait, init commands, accept/transfer, clear wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PWRUP;
            pwr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            last_q      <= 1'b1;
            lock_vld_q  <= 1'b0;
            lock_id_q   <= 1'b0;
`ifdef LCD_ARB_INIT_EN
            init_idx_q  <= '0;
`endif
        end else begin
            case (state_q)
                PWRUP: begin
                    if (pwr_cnt_q == PW'(T_PWRUP - 1)) begin
`ifdef LCD_ARB_INIT_EN
                        state_q <= INIT;
`else
                        state_q     <= IDLE;
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
`endif
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + 1'b1;
                    end
                end
                INIT: begin
`ifdef LCD_ARB_INIT_EN
                    rs_q    <= 1'b0;
                    data_q  <= init_cmd(init_idx_q);
                    state_q <= SETUP;
`else
                    state_q     <= IDLE;
                    init_done_q <= 1'b1;
                    busy_q      <= 1'b0;
`endif
                end
                IDLE: begin
                    if (grant_vld) begin
                        rs_q    <= bus.req_rs[grant_id];
                        data_q  <= bus.req_data[grant_id];
                        last_q  <= grant_id;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                        if (bus.req_lock[grant_id]) begin
                            lock_vld_q <= 1'b1;
                            lock_id_q  <= grant_id;
                        end else if (lock_vld_q && lock_id_q == grant_id) begin
                            lock_vld_q <= 1'b0;
                        end
                    end else begin
                        busy_q <= !init_done_q;
                    end
                end
                SETUP: begin
                    if (low_done) state_q <= STROBE;
                end
                STROBE: begin
                    if (high_done && clr_wait) state_q <= CLRWAIT;
                end
                CLRWAIT: begin
                    state_q <= CLRWAIT;
                end
                default: state_q <= PWRUP;
            endcase

            // A finished transfer returns to IDLE, or moves to the next init command
            if (xfer_end) begin
                if (init_done_q) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
`ifdef LCD_ARB_INIT_EN
                    if (init_idx_q == 3'(INIT_LEN - 1)) begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        init_idx_q <= init_idx_q + 1'b1;
                        state_q    <= INIT;
                    end
`else
                    state_q     <= IDLE;
                    init_done_q <= 1'b1;
                    busy_q      <= 1'b0;
`endif
                end
            end
        end
    end

    assign lcd_rs    = rs_q;
    assign lcd_data  = data_q;
    assign lcd_rw    = 1'b0;
    assign init_done = init_done_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with T_HALF=4, T_PWRUP=20, T_CLR=10.
// Follows LCD_ARB_INIT_EN the same way as the design.
module tb_lcd_bus_arbiter;
    import lcd_pkg::*;

    localparam int T_HALF  = 4;
    localparam int T_PWRUP = 20;
    localparam int T_CLR   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs, lcd_en, lcd_rw, init_done, busy;
    logic [7:0] lcd_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cyc_rel = 0;
    int held_bad = 0;
    int quiet, c0, c1, prev;

    lcd_bus_arbiter_if rif();

    lcd_bus_arbiter #(.T_HALF(T_HALF), .T_PWRUP(T_PWRUP), .T_CLR(T_CLR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (rif.slave),
        .lcd_rs    (lcd_rs),
        .lcd_en    (lcd_en),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .init_done (init_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_accept(input string tag, input logic [1:0] expd, output int at);
        int n;
        n = 0;
        #1;
        while (rif.req_ready == 2'b00 && n < 200) begin
            step;
            #1;
            n++;
        end
        if (n >= 200) chk({tag, "_timeout"}, 1, 0);
        chk(tag, rif.req_ready, expd);
        at = cyc;
    endtask

    task automatic wait_rise(input logic [7:0] expd, output int rise_at, output int low_n);
        int n;
        n = 0;
        low_n = 0;
        while (lcd_en !== 1'b1 && n < 300) begin
            if (lcd_data == expd) low_n++;
            if (rif.req_ready !== 2'b00) held_bad++;
            step;
            n++;
        end
        if (n >= 300) chk("rise_timeout", 1, 0);
        rise_at = cyc - cyc_rel;
    endtask

    task automatic wait_fall(output int hi_n);
        hi_n = 0;
        while (lcd_en === 1'b1 && hi_n < 300) begin
            step;
            hi_n++;
        end
    endtask

    task automatic powerup(input string tag);
`ifdef LCD_ARB_INIT_EN
        logic [7:0] cmds [5];
        int rise, prv, lown, hin;
        cmds = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        prv = 0;
`endif
        held_bad = 0;
        rst_n = 1'b1;
        cyc_rel = cyc;
`ifdef LCD_ARB_INIT_EN
        for (int i = 0; i < 5; i++) begin
            wait_rise(cmds[i], rise, lown);
            chk($sformatf("%s_cmd%0d_data", tag, i), lcd_data, cmds[i]);
            chk($sformatf("%s_cmd%0d_rs", tag, i), lcd_rs, 0);
            chk($sformatf("%s_cmd%0d_low", tag, i), lown, 4);
            if (i == 0) chk($sformatf("%s_first_rise", tag), rise, 25);
            else        chk($sformatf("%s_cmd%0d_gap", tag, i), rise - prv, (i == 3) ? 19 : 9);
            wait_fall(hin);
            chk($sformatf("%s_cmd%0d_high", tag, i), hin, 4);
            prv = rise;
        end
        chk({tag, "_init_done"}, init_done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_held"}, held_bad, 0);
`else
        for (int i = 0; i < 19; i++) begin
            step;
            if (init_done !== 1'b0 || lcd_en !== 1'b0 || rif.req_ready !== 2'b00 || busy !== 1'b1)
                held_bad++;
        end
        chk({tag, "_held"}, held_bad, 0);
        step;
        chk({tag, "_init_done"}, init_done, 1);
        chk({tag, "_busy"}, busy, 0);
`endif
    endtask

    initial begin
        rif.req_valid = 2'b11;
        rif.req_rs    = 2'b00;
        rif.req_data  = '0;
        rif.req_lock  = 2'b00;
        rst_n = 1'b0;
        step;
        step;
        #1;
        // reset state
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_ready", rif.req_ready, 2'b00);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 1);
        chk("rst_rw", lcd_rw, 0);
        rif.req_valid = 2'b00;
        @(negedge clk);

        powerup("pwr1");
        quiet = 0;
        repeat (5) begin
            step;
            if (lcd_en !== 1'b0) quiet++;
        end
        chk("idle_no_en", quiet, 0);
        chk("idle_busy", busy, 0);

        // both requesters valid: alternate 0,1,0,1 nine cycles apart
        rif.req_valid   = 2'b11;
        rif.req_rs      = 2'b11;
        rif.req_data[0] = 8'h41;
        rif.req_data[1] = 8'h42;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_accept($sformatf("rr_grant%0d", n), (n % 2 == 0) ? 2'b01 : 2'b10, c0);
            if (n > 0) chk($sformatf("rr_gap%0d", n), c0 - prev, 9);
            step;
            chk($sformatf("rr_data%0d", n), lcd_data, (n % 2 == 0) ? 8'h41 : 8'h42);
            chk($sformatf("rr_rs%0d", n), lcd_rs, 1);
            prev = c0;
        end

        // lock: req0 keeps the bus for two bytes despite req1 waiting
        rif.req_valid   = 2'b11;
        rif.req_data[0] = LCD_CMD_LINE1;
        rif.req_rs[0]   = 1'b0;
        rif.req_lock[0] = 1'b1;
        rif.req_data[1] = 8'h55;
        wait_accept("lock_g0", 2'b01, c0);
        step;
        chk("lock_d0", lcd_data, 8'h80);
        chk("lock_rs0", lcd_rs, 0);
        rif.req_data[0] = 8'h31;
        rif.req_rs[0]   = 1'b1;
        rif.req_lock[0] = 1'b0;
        wait_accept("lock_g1", 2'b01, c1);
        chk("lock_gap", c1 - c0, 9);
        step;
        chk("lock_d1", lcd_data, 8'h31);
        wait_accept("lock_g2", 2'b10, c0);
        step;
        chk("lock_d2", lcd_data, 8'h55);
        rif.req_valid = 2'b00;

        // clear command stretches the turnaround by T_CLR
        rif.req_valid   = 2'b10;
        rif.req_data[1] = 8'h01;
        rif.req_rs[1]   = 1'b0;
        wait_accept("clr_g0", 2'b10, c0);
        step;
        chk("clr_data", lcd_data, 8'h01);
        rif.req_data[1] = LCD_CMD_LINE2;
        repeat (11) step;
        chk("clrwait_busy", busy, 1);
        chk("clrwait_en", lcd_en, 0);
        wait_accept("clr_g1", 2'b10, c1);
        chk("clr_gap", c1 - c0, 19);
        step;
        chk("clr_next_data", lcd_data, 8'hC0);
        chk("clr_next_rs", lcd_rs, 0);
        rif.req_valid = 2'b00;

        // reset during the high phase, with a request left pending
        rif.req_valid   = 2'b01;
        rif.req_data[0] = 8'h46;
        rif.req_rs[0]   = 1'b1;
        wait_accept("mid_g", 2'b01, c0);
        repeat (5) step;
        chk("mid_en_high", lcd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", lcd_en, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_init_done", init_done, 0);
        step;
        step;
        powerup("pwr2");
        wait_accept("pend_g", 2'b01, c0);
        step;
        chk("pend_data", lcd_data, 8'h46);
        chk("pend_rs", lcd_rs, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL have parameter T_HALF, default 50000: clk cycles per lcd_en low phase and per lcd_en high phase.
REQ-002 SHALL have parameter T_PWRUP, default 750000: power-up wait in clk cycles.
REQ-003 SHALL have parameter T_CLR, default 100000: extra wait after a clear or home command.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid[1:0]  in  2  per-requester transfer request.
REQ-007 req_rs[1:0]  in  2  per-requester register select (0 = command, 1 = data).
REQ-008 req_data[0..1]  in  2x8  per-requester byte.
REQ-009 req_lock[1:0]  in  2  hold the grant after this transfer.
REQ-010 req_ready[1:0]  out  2  one-cycle accept strobe per requester.
REQ-011 lcd_rs, lcd_en  out  1 each  LCD1602 control lines; lcd_rw  out  1  constant 0.
REQ-012 lcd_data  out  8  LCD1602 data bus.
REQ-013 init_done  out  1  power-up sequence complete.
REQ-014 busy  out  1  high whenever no request can be accepted this cycle.

Function
REQ-015 States SHALL be: PWRUP, INIT, IDLE, SETUP, STROBE, CLRWAIT.
REQ-016 PWRUP SHALL count T_PWRUP cycles, then enter INIT.
REQ-017 INIT SHALL issue 0x38, 0x08, 0x01, 0x06, 0x0C in order with rs=0, each through SETUP/STROBE. After the last command, init_done SHALL go 1 and the state SHALL be IDLE.
REQ-018 In IDLE with init_done=1, req_ready[g] SHALL be asserted combinationally in the same cycle as req_valid[g] for granted requester g; rs and data are captured on that edge.
REQ-019 Arbitration:
- If locked_owner is set, only that requester SHALL be granted.
- Otherwise, with both valid, the grant SHALL go to the requester not served last (round-robin).
- With one valid, that requester SHALL be granted.
REQ-020 An accept with req_lock=1 SHALL set locked_owner to that requester; an accept from the owner with req_lock=0 SHALL clear it.
REQ-021 Accept at cycle k SHALL produce the following lcd_en sequence:
- cycles k+1..k+T_HALF: lcd_en=0;
- cycles k+T_HALF+1..k+2*T_HALF: lcd_en=1;
- cycle k+2*T_HALF+1: lcd_en=0.
REQ-022 lcd_rs and lcd_data SHALL update at k+1 and hold until the next transfer starts.
REQ-023 After STROBE, a command (rs=0) with data 0x01 or 0x02 SHALL enter CLRWAIT for T_CLR cycles; every other transfer SHALL return to IDLE.
REQ-024 The earliest next accept SHALL be cycle k+2*T_HALF+1, or T_CLR cycles later after a clear or home command.
REQ-025 busy SHALL be 0 only in IDLE with init_done=1.
REQ-026 Requests arriving before init_done SHALL be held off (ready=0), not dropped.
REQ-027 All outputs except req_ready SHALL be registered.

Reset
REQ-028 Reset SHALL set state=PWRUP, lcd_en=0, lcd_rs=0, lcd_data=0x00, req_ready=0, init_done=0, busy=1, locked_owner cleared, and last-served=1 (requester 0 wins first).
REQ-029 Reset assertion mid-transfer SHALL drop lcd_en immediately and restart the full power-up sequence.

Configuration
REQ-030 With LCD_ARB_INIT_EN defined, INIT SHALL run as in REQ-017.
REQ-031 Without LCD_ARB_INIT_EN, PWRUP SHALL go directly to IDLE with init_done=1, no commands are issued, and the init ROM is not synthesized.

Structure
REQ-032 Shared package lcd_pkg SHALL hold:
- the state enum;
- the five init command constants;
- default T_HALF, T_PWRUP and T_CLR values;
- the LCD command codes 0x01, 0x02, 0x80 and 0xC0.
REQ-033 Sub-module lcd_strobe_timer SHALL own the phase counter and the lcd_en generation, driven by start, clear-wait and done signals.

Verification (T_HALF=4, T_PWRUP=20, T_CLR=10)
REQ-034 Reset release with the macro defined -> bus shows 0x38,0x08,0x01,0x06,0x0C, each with 4 en-low and 4 en-high cycles, a 10-cycle gap after 0x01, then init_done=1.
REQ-035 After init, req_valid=2'b11 held, data 0x41/0x42 -> accepts alternate req0, req1, req0; accepts are 9 cycles apart.
REQ-036 req0 sends 0x80 with lock=1, then 0x31 with lock=0, while req1 is always valid -> both req0 bytes go out consecutively, then req1 is granted.
REQ-037 req1 sends command 0x01 -> next accept occurs 19 cycles after the 0x01 accept.
REQ-038 Reset asserted during the en-high phase -> lcd_en=0 in the same cycle, and the power-up count restarts from 0.
REQ-039 Macro undefined -> init_done=1 after 20 cycles, and no lcd_en pulse occurs before the first request.
